// File: rtl/ls_latch_bank_pkg.sv
// Shared types and sizing helpers for the latch bank and its capture log.
package ls_latch_pkg;

    typedef enum logic {
        LATCH_TRANSPARENT = 1'b0,
        LATCH_EDGE        = 1'b1
    } latch_mode_e;

    // Channel-index field width; a single-channel bank still carries one index bit.
    function automatic int chan_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic int log_entry_w(input int width, input int channels);
        return 1 + chan_w(channels) + width;
    endfunction

endpackage

// File: rtl/ls_latch_bank_if.sv
// Control/readback bundle between the CPU side and the latch bank.
interface ls_latch_bank_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) ();
    localparam int ENTRY_W = ls_latch_pkg::log_entry_w(WIDTH, CHANNELS);

    logic [WIDTH-1:0]    d;
    logic                mode;
    logic [CHANNELS-1:0] le;
    logic [CHANNELS-1:0] oe_b;
    logic                log_rd_en;
    logic                clr_ovf;
    logic [ENTRY_W-1:0]  log_data;
    logic                log_empty;
    logic                log_full;
    logic                log_ovf;

    modport master (
        output d, mode, le, oe_b, log_rd_en, clr_ovf,
        input  log_data, log_empty, log_full, log_ovf
    );

    modport slave (
        input  d, mode, le, oe_b, log_rd_en, clr_ovf,
        output log_data, log_empty, log_full, log_ovf
    );
endinterface

// File: rtl/ls_latch_log_fifo.sv
// First-word-fall-through capture log with sticky overflow flag.
module ls_latch_log_fifo #(
    parameter int ENTRY_W = 11,
    parameter int DEPTH   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    input  logic               clr_ovf,
    output logic [ENTRY_W-1:0] head,
    output logic               empty,
    output logic               full,
    output logic               ovf
);
    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic               do_pop;
    logic               do_push;
    logic               overflow;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    // A pop on a full log frees the slot the same-edge push needs.
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && full && !do_pop;
    assign head     = empty ? '0 : mem[rd_ptr];

    // NOTE: storage array has no reset; only pointers/count define validity, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (overflow)     ovf <= 1'b1;
            else if (clr_ovf) ovf <= 1'b0;
        end
    end

endmodule

// File: rtl/ls_latch_bank.sv
// Bank of shared-input bus latches (transparent or edge mode) with a capture log for debug.
module ls_latch_bank
    import ls_latch_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    ls_latch_bank_if.slave            bus,
    output wire [CHANNELS*WIDTH-1:0]  q
);
    localparam int CW      = chan_w(CHANNELS);
    localparam int ENTRY_W = log_entry_w(WIDTH, CHANNELS);

    latch_mode_e         mode_now;
    logic [WIDTH-1:0]    store [CHANNELS];
    logic [CHANNELS-1:0] le_prev;
    logic [CHANNELS-1:0] cap;
    logic [CW-1:0]       sel;
    logic                multi;
    logic [WIDTH-1:0]    cap_data;
    logic [ENTRY_W-1:0]  entry;

    assign mode_now = latch_mode_e'(bus.mode);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) store[i] <= '0;
            le_prev <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.le[i]) store[i] <= bus.d;
            end
            le_prev <= bus.le;
        end
    end

    // Transparent channels capture when the enable closes; edge channels capture while it is high.
    assign cap = (mode_now == LATCH_EDGE) ? bus.le : (le_prev & ~bus.le);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sel      = '0;
        multi    = ($countones(cap) > 1);
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (cap[i]) sel = CW'(i);
        end
        cap_data = (mode_now == LATCH_EDGE) ? bus.d : store[sel];
        entry    = {multi, sel, cap_data};
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_q
        assign q[g*WIDTH +: WIDTH] =
            bus.oe_b[g] ? {WIDTH{1'bz}} :
            ((mode_now == LATCH_TRANSPARENT && bus.le[g]) ? bus.d : store[g]);
    end

    ls_latch_log_fifo #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH)
    ) u_log (
        .clk       (clk),
        .rst       (rst),
        .push      (|cap),
        .push_data (entry),
        .pop       (bus.log_rd_en),
        .clr_ovf   (bus.clr_ovf),
        .head      (bus.log_data),
        .empty     (bus.log_empty),
        .full      (bus.log_full),
        .ovf       (bus.log_ovf)
    );

endmodule

// File: tb/tb_ls_latch_bank.sv
// Randomised bench for ls_latch_bank: queue-based reference model plus directed anchor cases.
module tb_ls_latch_bank;
    localparam int W     = 8;
    localparam int CH    = 4;
    localparam int DEPTH = 8;
    localparam int EW    = 11;

    logic clk = 1'b0;
    logic rst = 1'b0;
    wire [CH*W-1:0] q;

    ls_latch_bank_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

    ls_latch_bank #(.WIDTH(W), .CHANNELS(CH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave),
        .q   (q)
    );

    always #5 clk = ~clk;

    logic [W-1:0] q_val [CH];
    logic [CH-1:0] q_isz;
    for (genvar g = 0; g < CH; g++) begin : g_tap
        assign q_val[g] = q[g*W +: W];
        assign q_isz[g] = (q[g*W +: W] === {W{1'bz}});
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] mk(input int multi, input int ch, input int dat);
        return EW'((multi << 10) | (ch << 8) | dat);
    endfunction

    // Reference model: channel contents, previous enables and the log as a queue.
    logic [W-1:0]  m_store [CH];
    logic [CH-1:0] m_le_prev;
    logic [EW-1:0] m_log [$];
    logic          m_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) m_store[i] = '0;
            m_le_prev = '0;
            m_log.delete();
            m_ovf = 1'b0;
        end else begin
            int first;
            int hits;
            int dat;
            bit pop;
            first = -1;
            hits  = 0;
            dat   = 0;
            for (int i = 0; i < CH; i++) begin
                bit ev;
                ev = bus.mode ? bus.le[i] : (m_le_prev[i] && !bus.le[i]);
                if (ev) begin
                    hits++;
                    if (first < 0) begin
                        first = i;
                        dat   = bus.mode ? int'(bus.d) : int'(m_store[i]);
                    end
                end
            end
            pop = bus.log_rd_en && (m_log.size() > 0);
            if (first >= 0 && m_log.size() == DEPTH && !pop) begin
                m_ovf = 1'b1;
            end else begin
                if (bus.clr_ovf) m_ovf = 1'b0;
                if (pop) void'(m_log.pop_front());
                if (first >= 0) m_log.push_back(mk(hits > 1, first, dat));
            end
            if (first >= 0 && pop && m_log.size() == 0) ; // unreachable guard kept out
            for (int i = 0; i < CH; i++) if (bus.le[i]) m_store[i] = bus.d;
            m_le_prev = bus.le;
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < CH; i++) begin
                if (bus.oe_b[i]) begin
                    check("q_hiz", q_isz[i], 1);
                end else begin
                    check("q_driven", q_isz[i], 0);
                    check("q_value", q_val[i],
                          (!bus.mode && bus.le[i]) ? bus.d : m_store[i]);
                end
            end
            check("log_empty", bus.log_empty, m_log.size() == 0);
            check("log_full", bus.log_full, m_log.size() == DEPTH);
            check("log_ovf", bus.log_ovf, m_ovf);
            if (m_log.size() > 0) check("log_head", bus.log_data, m_log[0]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.d = '0; bus.mode = 1'b0; bus.le = '0; bus.oe_b = '1;
        bus.log_rd_en = 1'b0; bus.clr_ovf = 1'b0;
        #1 rst = 1'b1;
        #12;
        check("rst_empty", bus.log_empty, 1);
        check("rst_full", bus.log_full, 0);
        check("rst_ovf", bus.log_ovf, 0);
        check("rst_data", bus.log_data, 0);
        step();
        rst = 1'b0;
        cmp_en = 1'b1;

        // Tristate and ignored empty pop
        bus.oe_b = 4'b1111;
        @(negedge clk);
        for (int i = 0; i < CH; i++) check("tri_all_z", q_isz[i], 1);
        bus.oe_b = 4'b1110;
        @(negedge clk);
        check("tri_ch0_drv", q_isz[0], 0);
        check("tri_ch0_val", q_val[0], 8'h00);
        check("tri_ch3_z", q_isz[3], 1);
        bus.log_rd_en = 1'b1;
        step();
        bus.log_rd_en = 1'b0;
        @(negedge clk);
        check("empty_pop", bus.log_empty, 1);

        // Transparent latch on channel 1
        bus.oe_b = 4'b0000; bus.mode = 1'b0; bus.le = 4'b0010; bus.d = 8'h3C;
        @(negedge clk);
        check("tr_follow1", q_val[1], 8'h3C);
        step();
        bus.d = 8'hA5;
        @(negedge clk);
        check("tr_follow2", q_val[1], 8'hA5);
        step();
        bus.le = 4'b0000; bus.d = 8'h11;
        @(negedge clk);
        check("tr_hold", q_val[1], 8'hA5);
        step();
        @(negedge clk);
        check("tr_logged", bus.log_empty, 0);
        check("tr_entry", bus.log_data, 11'h1A5);
        bus.log_rd_en = 1'b1;
        step();
        bus.log_rd_en = 1'b0;
        @(negedge clk);
        check("tr_one_entry", bus.log_empty, 1);

        // Edge register on channel 2
        bus.mode = 1'b1; bus.le = 4'b0100; bus.d = 8'h5A;
        step();
        bus.le = 4'b0000; bus.d = 8'hFF;
        @(negedge clk);
        check("edge_q", q_val[2], 8'h5A);
        check("edge_entry", bus.log_data, 11'h25A);
        step();
        bus.log_rd_en = 1'b1;
        step();
        bus.log_rd_en = 1'b0;
        @(negedge clk);
        check("edge_one_entry", bus.log_empty, 1);

        // Simultaneous capture on channels 1 and 3
        bus.le = 4'b1010; bus.d = 8'h77;
        step();
        bus.le = 4'b0000;
        @(negedge clk);
        check("sim_q1", q_val[1], 8'h77);
        check("sim_q3", q_val[3], 8'h77);
        check("sim_entry", bus.log_data, 11'h577);
        bus.log_rd_en = 1'b1;
        step();
        bus.log_rd_en = 1'b0;
        @(negedge clk);
        check("sim_one_entry", bus.log_empty, 1);

        // Overflow, clear, pop+push while full, ordered drain
        bus.le = 4'b0001;
        for (int k = 1; k <= 9; k++) begin
            bus.d = W'(k);
            step();
        end
        bus.le = 4'b0000;
        @(negedge clk);
        check("ovf_full", bus.log_full, 1);
        check("ovf_set", bus.log_ovf, 1);
        check("ovf_head", bus.log_data, 11'h001);
        bus.clr_ovf = 1'b1;
        step();
        bus.clr_ovf = 1'b0;
        @(negedge clk);
        check("ovf_clr", bus.log_ovf, 0);
        bus.le = 4'b0001; bus.d = 8'hAA; bus.log_rd_en = 1'b1;
        step();
        bus.le = 4'b0000; bus.log_rd_en = 1'b0;
        @(negedge clk);
        check("pp_full", bus.log_full, 1);
        check("pp_no_ovf", bus.log_ovf, 0);
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            check("drain_order", bus.log_data, (k < 7) ? mk(0, 0, k + 2) : 11'h0AA);
            bus.log_rd_en = 1'b1;
            step();
            bus.log_rd_en = 1'b0;
        end
        @(negedge clk);
        check("drain_empty", bus.log_empty, 1);

        // Reset mid-stream with three logged entries
        bus.le = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            bus.d = W'(8'h31 + k);
            step();
        end
        bus.le = 4'b0000;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_empty", bus.log_empty, 1);
        check("mid_rst_ovf", bus.log_ovf, 0);
        @(negedge clk);
        check("mid_rst_q0", q_val[0], 8'h00);
        step();
        rst = 1'b0;

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bus.d = W'($urandom);
            if ($urandom_range(0, 15) == 0) bus.mode = ~bus.mode;
            if ($urandom_range(0, 2) == 0) bus.le = CH'($urandom & $urandom);
            bus.oe_b      = CH'($urandom);
            bus.log_rd_en = ($urandom_range(0, 2) == 0);
            bus.clr_ovf   = ($urandom_range(0, 11) == 0);
            step();
        end
        bus.log_rd_en = 1'b0;
        bus.clr_ovf   = 1'b0;
        @(negedge clk);
        cmp_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
